// File: rtl/exp_pkg.sv
// -----------------------------------------------------------------------------
// exp_pkg
// Shared definitions for the full-range exponential wrapper.
//   q32_t    : unsigned q32.32 fixed-point word (64 bits, 32 fraction bits)
//   E_Q32    : e in q32.32
//   INV_E_Q32: 1/e in q32.32
//   state_t  : control FSM encoding of exp_range_reducer
// -----------------------------------------------------------------------------
package exp_pkg;

  typedef logic [63:0] q32_t;

  localparam q32_t E_Q32     = 64'h0000_0002_B7E1_5163;
  localparam q32_t INV_E_Q32 = 64'h0000_0000_5E2D_58D9;
  localparam q32_t Q32_ONES  = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    SCALE  = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/q32_mul.sv
// -----------------------------------------------------------------------------
// q32_mul
// Unsigned q32.32 x q32.32 multiply. The full 128-bit product is q64.64; the
// q32.32 result is bits [95:32] (truncated). Any set bit in [127:96] means
// the integer part no longer fits in 32 bits.
//   a, b : q32.32 operands
//   prod : truncated q32.32 product
//   ovf  : product integer part exceeds 32 bits
// -----------------------------------------------------------------------------
module q32_mul
  import exp_pkg::*;
(
  input  q32_t a,
  input  q32_t b,
  output q32_t prod,
  output logic ovf
);

  logic [127:0] full;
  logic         unused_frac_bits;

  assign full = {64'h0, a} * {64'h0, b};
  assign prod = full[95:32];
  assign ovf  = |full[127:96];

  // Sub-LSB fraction bits are dropped by truncation.
  assign unused_frac_bits = ^full[31:0];

endmodule

// File: rtl/exp_range_reducer.sv
// -----------------------------------------------------------------------------
// exp_range_reducer
// Computes e^x for an arbitrary signed q32.32 x by splitting x = n + r with
// n = floor(x) (the integer word) and r in [0,1) (the fraction word). r goes
// to an external combinational exp LUT; e^r is captured, then multiplied by
// e (n > 0) or 1/e (n < 0) |n| times. |n| > MAX_INT saturates immediately;
// an integer-part overflow while scaling up also saturates.
//
// Handshake: a request is taken on any rising edge where i_valid && o_ready.
// o_ready is high only when idle with no result strobe in flight; i_valid
// while o_ready is low is ignored, never queued. o_valid is a single-cycle
// strobe with no backpressure; o_exp / o_sat hold until the next result.
//
// Ports:
//   i_clk, i_reset : clock, asynchronous active-high reset
//   i_valid, i_x   : request strobe and signed q32.32 argument
//   o_ready        : request may be accepted this cycle
//   o_lut_arg      : registered fraction r to the LUT input
//   i_lut_value    : e^r from the LUT (combinational from o_lut_arg)
//   o_valid        : result strobe
//   o_exp, o_sat   : unsigned q32.32 e^x, clamp flag
//   o_dbg_state    : current FSM state
// -----------------------------------------------------------------------------
module exp_range_reducer
  import exp_pkg::*;
#(
  parameter int MAX_INT = 22
) (
  input  logic   i_clk,
  input  logic   i_reset,
  input  logic   i_valid,
  input  q32_t   i_x,
  output logic   o_ready,
  output q32_t   o_lut_arg,
  input  q32_t   i_lut_value,
  output logic   o_valid,
  output q32_t   o_exp,
  output logic   o_sat,
  output state_t o_dbg_state
);

  localparam int                 CNT_W = $clog2(MAX_INT + 2);
  localparam logic signed [31:0] MAX_S = 32'(MAX_INT);

  state_t             state;
  state_t             state_nxt;
  q32_t               acc;
  logic [CNT_W-1:0]   cnt;
  logic               neg;

  logic signed [31:0] n;
  logic [31:0]        abs_n;
  logic               n_big;
  logic               n_small;
  logic               accept;
  logic               cnt_zero;

  q32_t               mul_k;
  q32_t               mul_prod;
  logic               mul_ovf;
  logic               scale_ovf;

  assign n        = $signed(i_x[63:32]);
  assign abs_n    = n[31] ? 32'(-n) : 32'(n);
  assign n_big    = n > MAX_S;
  assign n_small  = n < -MAX_S;
  assign cnt_zero = (cnt == '0);

  // The done strobe is registered, so the FSM is already back in IDLE
  // during the o_valid cycle; ready is held off for that one cycle.
  assign o_ready  = (state == IDLE) && !o_valid && !i_reset;
  assign accept   = i_valid && o_ready;

  assign mul_k    = neg ? INV_E_Q32 : E_Q32;
  // Scaling by 1/e can only shrink the value, so only upward scaling clamps.
  assign scale_ovf = !neg && mul_ovf;

  assign o_dbg_state = state;

  q32_mul u_mul (
    .a    (acc),
    .b    (mul_k),
    .prod (mul_prod),
    .ovf  (mul_ovf)
  );

  // State register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = (n_big || n_small) ? DONE : LOOKUP;
        end
      end
      LOOKUP: state_nxt = SCALE;
      SCALE: begin
        if (cnt_zero || scale_ovf) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      acc       <= '0;
      cnt       <= '0;
      neg       <= 1'b0;
      o_lut_arg <= '0;
      o_exp     <= '0;
      o_sat     <= 1'b0;
      o_valid   <= 1'b0;
    end else begin
      o_valid <= (state == DONE);
      case (state)
        IDLE: begin
          if (accept) begin
            if (n_big) begin
              o_exp <= Q32_ONES;
              o_sat <= 1'b1;
            end else if (n_small) begin
              o_exp <= '0;
              o_sat <= 1'b1;
            end else begin
              o_lut_arg <= {32'h0, i_x[31:0]};
              neg       <= n[31];
              cnt       <= CNT_W'(abs_n);
              o_sat     <= 1'b0;
            end
          end
        end
        LOOKUP: acc <= i_lut_value;
        SCALE: begin
          if (cnt_zero) begin
            o_exp <= acc;
          end else if (scale_ovf) begin
            o_exp <= Q32_ONES;
            o_sat <= 1'b1;
          end else begin
            acc <= mul_prod;
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
